eviction_plru: RTL and testbench
================================

Name: eviction_plru

Overview:
- Tree pseudo-LRU replacement unit for the fully associative cache. It sits directly downstream of the way-lookup stage and consumes its hit, miss and hitWay results.
- It tracks per-way valid bits and recency, and it supplies a one-hot victim way to the controller on request.
- It holds the victim stable until the controller reports the fill complete.

Parameters:
- NUM_WAYS, 4, number of ways. Must be a power of 2 and at least 2.
- TREE_BITS, NUM_WAYS-1, PLRU node count. Localparam only; not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- lookupValid  input  1  qualifies hit, miss and hitWay for this cycle.
- hit  input  1  lookup hit.
- miss  input  1  lookup miss. Informational only; no state change.
- hitWay  input  NUM_WAYS  one-hot way that hit.
- victimReq  input  1  controller requests a victim. Sampled only in IDLE.
- victimValid  output  1  victimWay is valid and held.
- victimWay  output  NUM_WAYS  one-hot selected victim.
- fillDone  input  1  controller finished filling victimWay. Honoured only while victimValid=1.
- invalidate  input  1  clear the valid bit of invalidateWay.
- invalidateWay  input  NUM_WAYS  one-hot way to invalidate.
- allValid  output  1  all valid bits set (combinational from register).
- protocolError  output  1  registered, one-cycle pulse.

Behaviour:
- Reset values:
  - tree=0, valid=0, state=IDLE.
  - victimValid=0, victimWay=0, protocolError=0, allValid=0.
- Tree encoding:
  - Heap-indexed: root is node 0; the children of node i are 2i+1 and 2i+2.
  - Node bit 0 means the victim lies in the lower-index half; bit 1 means the upper half.
- Touch(w): every node on the path to way w is set to point away from w. Nodes off the path are unchanged.
- Victim selection:
  - If any valid bit is 0, the victim is the lowest-index invalid way.
  - Otherwise, walk the tree from the root following the node bits.
- FSM, IDLE to HOLD:
  - In IDLE, victimReq=1 latches the selection into victimWay and enters HOLD.
  - victimValid=1 from the next cycle, so latency is 1 cycle.
- FSM, HOLD:
  - victimWay and victimValid are held constant regardless of hits, invalidates or victimReq.
  - fillDone=1 sets valid[victimWay], applies Touch(victimWay) and enters IDLE. victimValid=0 on the next cycle.
- FSM, back-to-back:
  - A new victimReq is accepted no earlier than the cycle after returning to IDLE.
  - A victimReq held high across a fillDone is therefore served with 1 idle cycle.
- Hit update: lookupValid & hit & hitWay one-hot applies Touch(hitWay) in any state.
- Ordering when fill and hit coincide in the same cycle:
  - Apply Touch(fill) first, then Touch(hit) on the result.
  - Where the two paths share nodes, the hit's value wins.
- Invalidate:
  - Clears valid[invalidateWay]; the tree is unchanged.
  - Coincident with fillDone on the same way: the fill wins and valid=1.
  - Invalidate of the held victim in HOLD does not change victimWay.
- Protocol errors:
  - Condition: lookupValid with (hit & miss), or hit with hitWay not one-hot.
  - Response: protocolError pulses on the next cycle and no tree update occurs.
- Protocol errors are not flagged for fillDone in IDLE or for a non-one-hot invalidateWay. Both are ignored with no state change.
- miss alone never changes state. The controller issues victimReq after a miss.
- Reset mid-HOLD immediately clears victimValid, tree and valid. A pending fill is lost.

Test Plan:
1. Fills from reset:
   - Stimulus (NUM_WAYS=4): reset, then 4 × {victimReq; wait victimValid; fillDone}.
   - Required: victimWay=0001, 0010, 0100, 1000 in order, and allValid=1 after the 4th fill.
2. Tree victim after fills:
   - Stimulus: after scenario 1, victimReq.
   - Required: victimWay=0001 (tree root=0, node1=0).
3. Hit update:
   - Stimulus: after scenario 2's fill, lookupValid hit hitWay=0001 in IDLE, then victimReq.
   - Required: victimWay=0100.
4. Hold stability:
   - Stimulus: in HOLD with victimWay=0100, hit on 0100 and invalidate 0100 on consecutive cycles.
   - Required: victimWay stays 0100 and victimValid stays 1 until fillDone. After fillDone, valid[2]=1.
5. Invalidate priority:
   - Stimulus: all valid; invalidate 0010; victimReq.
   - Required: victimWay=0010 regardless of tree state.
6. Protocol error and reset:
   - Stimulus: lookupValid hit with hitWay=0011.
   - Required: protocolError=1 for exactly one cycle and the tree is unchanged.
   - Stimulus: assert rst asynchronously mid-HOLD.
   - Required: victimValid=0 and allValid=0 immediately.

Source files
------------

// File: rtl/eviction_plru_if.sv
// Bus bundle between the PLRU replacement unit and the lookup stage and cache controller.
interface eviction_plru_if #(
  parameter int NUM_WAYS = 4
);
  logic                lookupValid;
  logic                hit;
  logic                miss;
  logic [NUM_WAYS-1:0] hitWay;
  logic                victimReq;
  logic                victimValid;
  logic [NUM_WAYS-1:0] victimWay;
  logic                fillDone;
  logic                invalidate;
  logic [NUM_WAYS-1:0] invalidateWay;
  logic                allValid;
  logic                protocolError;

  modport master (
    output lookupValid, hit, miss, hitWay, victimReq, fillDone, invalidate, invalidateWay,
    input  victimValid, victimWay, allValid, protocolError
  );

  modport slave (
    input  lookupValid, hit, miss, hitWay, victimReq, fillDone, invalidate, invalidateWay,
    output victimValid, victimWay, allValid, protocolError
  );
endinterface

// File: rtl/eviction_plru.sv
// Tree pseudo-LRU victim selection with per-way valid bits for a fully associative cache.
// Handshake: victimReq is taken only in IDLE; victimWay/victimValid then hold until fillDone closes the HOLD.
module eviction_plru #(
  parameter int NUM_WAYS = 4
) (
  input logic            clk,
  input logic            rst,
  eviction_plru_if.slave bus
);
  localparam int TREE_BITS = NUM_WAYS - 1;
  localparam int IDX_W     = $clog2(NUM_WAYS);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t              state_q, state_n;
  logic [TREE_BITS-1:0] tree_q, tree_n;
  logic [NUM_WAYS-1:0]  valid_q, valid_n;
  logic [NUM_WAYS-1:0]  victim_q, victim_n;
  logic                 perr_q, perr_n;
  logic                 hit_ok;
  logic                 fill;

  function automatic logic is_onehot(input logic [NUM_WAYS-1:0] x);
    return (x != '0) && ((x & (x - NUM_WAYS'(1))) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] encode(input logic [NUM_WAYS-1:0] x);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_WAYS; i++)
      if (x[i]) idx = IDX_W'(i);
    return idx;
  endfunction

  // Walking down from the root, each node on the path is pointed at the other half.
  function automatic logic [TREE_BITS-1:0] touch(input logic [TREE_BITS-1:0] t,
                                                 input logic [IDX_W-1:0] w);
    logic [TREE_BITS-1:0] r;
    logic                 b;
    int                   node;
    r    = t;
    node = 0;
    for (int l = 0; l < IDX_W; l++) begin
      b       = w[IDX_W-1-l];
      r[node] = ~b;
      node    = 2 * node + 1 + (b ? 1 : 0);
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] tree_walk(input logic [TREE_BITS-1:0] t);
    logic [IDX_W-1:0] idx;
    logic             b;
    int               node;
    idx  = '0;
    node = 0;
    for (int l = 0; l < IDX_W; l++) begin
      b                = t[node];
      idx[IDX_W-1-l]   = b;
      node             = 2 * node + 1 + (b ? 1 : 0);
    end
    return idx;
  endfunction

  function automatic logic [IDX_W-1:0] first_invalid(input logic [NUM_WAYS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--)
      if (!v[i]) idx = IDX_W'(i);
    return idx;
  endfunction

  always_comb begin
    state_n  = state_q;
    tree_n   = tree_q;
    valid_n  = valid_q;
    victim_n = victim_q;
    perr_n   = bus.lookupValid && bus.hit && (bus.miss || !is_onehot(bus.hitWay));
    hit_ok   = bus.lookupValid && bus.hit && !bus.miss && is_onehot(bus.hitWay);
    fill     = (state_q == HOLD) && bus.fillDone;

    if (bus.invalidate && is_onehot(bus.invalidateWay))
      valid_n = valid_n & ~bus.invalidateWay;

    // Fill is applied before the hit so the hit owns any shared nodes.
    if (fill) begin
      valid_n = valid_n | victim_q;
      tree_n  = touch(tree_n, encode(victim_q));
    end
    if (hit_ok)
      tree_n = touch(tree_n, encode(bus.hitWay));

    case (state_q)
      IDLE: begin
        if (bus.victimReq) begin
          state_n  = HOLD;
          victim_n = NUM_WAYS'(1) << ((&valid_q) ? tree_walk(tree_q) : first_invalid(valid_q));
        end
      end
      HOLD: begin
        if (bus.fillDone) begin
          state_n  = IDLE;
          victim_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tree_q   <= '0;
      valid_q  <= '0;
      victim_q <= '0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      tree_q   <= tree_n;
      valid_q  <= valid_n;
      victim_q <= victim_n;
      perr_q   <= perr_n;
    end
  end

  assign bus.victimValid   = (state_q == HOLD);
  assign bus.victimWay     = victim_q;
  assign bus.allValid      = &valid_q;
  assign bus.protocolError = perr_q;
endmodule

// File: tb/tb_eviction_plru.sv
// Directed bench for eviction_plru with NUM_WAYS=4; expected ways are worked out by hand from the tree rules.
module tb_eviction_plru;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  eviction_plru_if #(.NUM_WAYS(4)) bus ();

  eviction_plru #(.NUM_WAYS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks: called at a negedge, return at the following negedge.
  task automatic pulse_req();
    bus.victimReq = 1'b1;
    @(negedge clk);
    bus.victimReq = 1'b0;
  endtask

  task automatic pulse_fill();
    bus.fillDone = 1'b1;
    @(negedge clk);
    bus.fillDone = 1'b0;
  endtask

  task automatic pulse_hit(input logic [3:0] way, input logic miss_v);
    bus.lookupValid = 1'b1;
    bus.hit         = 1'b1;
    bus.miss        = miss_v;
    bus.hitWay      = way;
    @(negedge clk);
    bus.lookupValid = 1'b0;
    bus.hit         = 1'b0;
    bus.miss        = 1'b0;
    bus.hitWay      = '0;
  endtask

  task automatic pulse_inval(input logic [3:0] way);
    bus.invalidate    = 1'b1;
    bus.invalidateWay = way;
    @(negedge clk);
    bus.invalidate    = 1'b0;
    bus.invalidateWay = '0;
  endtask

  task automatic test_reset();
    bus.lookupValid = 0; bus.hit = 0; bus.miss = 0; bus.hitWay = '0;
    bus.victimReq = 0; bus.fillDone = 0; bus.invalidate = 0; bus.invalidateWay = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.victimValid !== 1'b0) begin tests_failed++; $display("FAIL reset victimValid: got %b expected 0", bus.victimValid); end
    tests_run++;
    if (bus.victimWay !== 4'b0000) begin tests_failed++; $display("FAIL reset victimWay: got %b expected 0000", bus.victimWay); end
    tests_run++;
    if (bus.allValid !== 1'b0) begin tests_failed++; $display("FAIL reset allValid: got %b expected 0", bus.allValid); end
    tests_run++;
    if (bus.protocolError !== 1'b0) begin tests_failed++; $display("FAIL reset protocolError: got %b expected 0", bus.protocolError); end
  endtask

  task automatic test_fills_from_reset();
    logic [3:0] exp_way;
    for (int i = 0; i < 4; i++) begin
      exp_way = 4'b0001 << i;
      pulse_req();
      tests_run++;
      if (bus.victimValid !== 1'b1) begin tests_failed++; $display("FAIL fill%0d victimValid: got %b expected 1", i, bus.victimValid); end
      tests_run++;
      if (bus.victimWay !== exp_way) begin tests_failed++; $display("FAIL fill%0d victimWay: got %b expected %b", i, bus.victimWay, exp_way); end
      pulse_fill();
      tests_run++;
      if (bus.victimValid !== 1'b0) begin tests_failed++; $display("FAIL fill%0d release: got %b expected 0", i, bus.victimValid); end
      tests_run++;
      if (bus.allValid !== (i == 3)) begin tests_failed++; $display("FAIL fill%0d allValid: got %b expected %b", i, bus.allValid, (i == 3)); end
    end
  endtask

  task automatic test_tree_victim();
    pulse_req();
    tests_run++;
    if (bus.victimWay !== 4'b0001) begin tests_failed++; $display("FAIL tree_victim way: got %b expected 0001", bus.victimWay); end
    pulse_fill();
  endtask

  task automatic test_hit_update();
    pulse_hit(4'b0001, 1'b0);
    pulse_req();
    tests_run++;
    if (bus.victimWay !== 4'b0100) begin tests_failed++; $display("FAIL hit_update way: got %b expected 0100", bus.victimWay); end
  endtask

  task automatic test_hold_stability();
    pulse_hit(4'b0100, 1'b0);
    tests_run++;
    if (bus.victimWay !== 4'b0100 || bus.victimValid !== 1'b1) begin tests_failed++; $display("FAIL hold after hit: got %b/%b expected 0100/1", bus.victimWay, bus.victimValid); end
    pulse_inval(4'b0100);
    tests_run++;
    if (bus.victimWay !== 4'b0100 || bus.victimValid !== 1'b1) begin tests_failed++; $display("FAIL hold after inval: got %b/%b expected 0100/1", bus.victimWay, bus.victimValid); end
    tests_run++;
    if (bus.allValid !== 1'b0) begin tests_failed++; $display("FAIL hold inval allValid: got %b expected 0", bus.allValid); end
    pulse_req();
    tests_run++;
    if (bus.victimWay !== 4'b0100 || bus.victimValid !== 1'b1) begin tests_failed++; $display("FAIL hold after req: got %b/%b expected 0100/1", bus.victimWay, bus.victimValid); end
    pulse_fill();
    tests_run++;
    if (bus.victimValid !== 1'b0) begin tests_failed++; $display("FAIL hold release: got %b expected 0", bus.victimValid); end
    tests_run++;
    if (bus.allValid !== 1'b1) begin tests_failed++; $display("FAIL hold refill allValid: got %b expected 1", bus.allValid); end
  endtask

  task automatic test_invalidate_priority();
    pulse_inval(4'b0010);
    tests_run++;
    if (bus.allValid !== 1'b0) begin tests_failed++; $display("FAIL inval allValid: got %b expected 0", bus.allValid); end
    pulse_req();
    tests_run++;
    if (bus.victimWay !== 4'b0010) begin tests_failed++; $display("FAIL inval victim: got %b expected 0010", bus.victimWay); end
    pulse_fill();
    tests_run++;
    if (bus.allValid !== 1'b1) begin tests_failed++; $display("FAIL inval refill allValid: got %b expected 1", bus.allValid); end
  endtask

  task automatic test_protocol_error();
    pulse_hit(4'b0011, 1'b0);
    tests_run++;
    if (bus.protocolError !== 1'b1) begin tests_failed++; $display("FAIL perr 0011 pulse: got %b expected 1", bus.protocolError); end
    @(negedge clk);
    tests_run++;
    if (bus.protocolError !== 1'b0) begin tests_failed++; $display("FAIL perr 0011 width: got %b expected 0", bus.protocolError); end
    pulse_hit(4'b1100, 1'b0);
    tests_run++;
    if (bus.protocolError !== 1'b1) begin tests_failed++; $display("FAIL perr 1100 pulse: got %b expected 1", bus.protocolError); end
    pulse_hit(4'b1000, 1'b1);
    tests_run++;
    if (bus.protocolError !== 1'b1) begin tests_failed++; $display("FAIL perr hit_miss pulse: got %b expected 1", bus.protocolError); end
    @(negedge clk);
    tests_run++;
    if (bus.protocolError !== 1'b0) begin tests_failed++; $display("FAIL perr hit_miss width: got %b expected 0", bus.protocolError); end
    pulse_req();
    tests_run++;
    if (bus.victimWay !== 4'b1000) begin tests_failed++; $display("FAIL perr tree unchanged: got %b expected 1000", bus.victimWay); end
    pulse_fill();
  endtask

  task automatic test_ignored_inputs();
    bus.lookupValid = 1'b1; bus.miss = 1'b1; bus.hitWay = 4'b0001;
    @(negedge clk);
    bus.lookupValid = 1'b0; bus.miss = 1'b0; bus.hitWay = '0;
    pulse_fill();
    pulse_inval(4'b0110);
    tests_run++;
    if (bus.protocolError !== 1'b0 || bus.victimValid !== 1'b0) begin tests_failed++; $display("FAIL ignored flags: got %b/%b expected 0/0", bus.protocolError, bus.victimValid); end
    tests_run++;
    if (bus.allValid !== 1'b1) begin tests_failed++; $display("FAIL ignored allValid: got %b expected 1", bus.allValid); end
    pulse_req();
    tests_run++;
    if (bus.victimWay !== 4'b0001) begin tests_failed++; $display("FAIL ignored victim: got %b expected 0001", bus.victimWay); end
  endtask

  task automatic test_fill_hit_coincide();
    bus.fillDone = 1'b1;
    pulse_hit(4'b0100, 1'b0);
    bus.fillDone = 1'b0;
    tests_run++;
    if (bus.victimValid !== 1'b0) begin tests_failed++; $display("FAIL coincide release: got %b expected 0", bus.victimValid); end
    pulse_req();
    tests_run++;
    if (bus.victimWay !== 4'b0010) begin tests_failed++; $display("FAIL coincide order: got %b expected 0010", bus.victimWay); end
    pulse_fill();
  endtask

  task automatic test_back_to_back();
    bus.victimReq = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.victimValid !== 1'b1 || bus.victimWay !== 4'b1000) begin tests_failed++; $display("FAIL b2b first: got %b/%b expected 1/1000", bus.victimValid, bus.victimWay); end
    bus.fillDone = 1'b1;
    @(negedge clk);
    bus.fillDone = 1'b0;
    tests_run++;
    if (bus.victimValid !== 1'b0) begin tests_failed++; $display("FAIL b2b idle gap: got %b expected 0", bus.victimValid); end
    @(negedge clk);
    bus.victimReq = 1'b0;
    tests_run++;
    if (bus.victimValid !== 1'b1 || bus.victimWay !== 4'b0001) begin tests_failed++; $display("FAIL b2b second: got %b/%b expected 1/0001", bus.victimValid, bus.victimWay); end
  endtask

  task automatic test_reset_mid_hold();
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.victimValid !== 1'b0 || bus.allValid !== 1'b0) begin tests_failed++; $display("FAIL async reset: got %b/%b expected 0/0", bus.victimValid, bus.allValid); end
    tests_run++;
    if (bus.victimWay !== 4'b0000) begin tests_failed++; $display("FAIL async reset way: got %b expected 0000", bus.victimWay); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_req();
    tests_run++;
    if (bus.victimWay !== 4'b0001) begin tests_failed++; $display("FAIL post reset victim: got %b expected 0001", bus.victimWay); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    test_reset();
    test_fills_from_reset();
    test_tree_victim();
    test_hit_update();
    test_hold_stability();
    test_invalidate_priority();
    test_protocol_error();
    test_ignored_inputs();
    test_fill_hit_coincide();
    test_back_to_back();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
